// File: rtl/mini_src_control_unit.sv
// rtl/mini_src_control_unit.sv - hardwired fetch/execute sequencer for the mini SRC datapath
module mini_src_control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zhiout,
    output logic        Zloout,
    output logic        MDRout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [3:0]  alu_op,
    output logic [31:0] c_sext,
    output logic [3:0]  tstate,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_DISP  = 4'd9,
        S_HALT  = 4'd15
    } state_t;

    state_t      state_q, state_d, cur;
    logic        illegal_q, illegal_d;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        is_alu, is_md, is_ld, is_st, is_nop, is_halt, is_ill;

    assign op     = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];
    assign c_sext = {{13{ir[18]}}, ir[18:0]};

    assign is_ld   = (op == 5'd0);
    assign is_st   = (op == 5'd1);
    assign is_alu  = (op >= 5'd2) && (op <= 5'd10);
    assign is_md   = (op == 5'd11) || (op == 5'd12);
    assign is_nop  = (op == 5'd24);
    assign is_halt = (op == 5'd25);
    assign is_ill  = !(is_ld || is_st || is_alu || is_md || is_nop || is_halt);

    // S_DISP is the cycle right after the T2 edge: it resolves against the freshly
    // loaded ir so nop/halt take no extra cycle and it is never visible on tstate.
    always_comb begin
        cur = state_q;
        if (state_q == S_DISP) begin
            if (is_alu || is_md || is_ld || is_st) cur = S_T3;
            else if (is_nop)                       cur = S_T0;
            else                                   cur = S_HALT;
        end
    end

    always_comb begin
        state_d   = cur;
        illegal_d = illegal_q;
        case (cur)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = mem_ready ? S_T2 : S_T1;
            S_T2:    state_d = S_DISP;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = is_alu ? S_T0 : S_T6;
            S_T6: begin
                if (is_md)      state_d = S_T0;
                else if (is_ld) state_d = mem_ready ? S_T7 : S_T6;
                else            state_d = S_T7;
            end
            S_T7: begin
                if (is_ld) state_d = S_T0;
                else       state_d = mem_ready ? S_T0 : S_T7;
            end
            default: state_d = S_HALT;
        endcase
        if (state_q == S_DISP && cur == S_HALT) illegal_d = is_ill;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_RESET;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        PCout  = 1'b0; Zhiout = 1'b0; Zloout = 1'b0; MDRout = 1'b0; Cout  = 1'b0;
        PCin   = 1'b0; IRin   = 1'b0; MARin  = 1'b0; MDRin  = 1'b0; Yin   = 1'b0;
        Zin    = 1'b0; HIin   = 1'b0; LOin   = 1'b0; IncPC  = 1'b0; Read  = 1'b0;
        Write  = 1'b0;
        Rin    = 16'h0000;
        Rout   = 16'h0000;
        alu_op = 4'b0000;
        halted = 1'b0;
        illegal = 1'b0;
        case (cur)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            S_T1: begin Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin Rout = 16'h0001 << rb; Yin = 1'b1; end
            S_T4: begin
                Zin = 1'b1;
                if (is_ld || is_st) Cout = 1'b1;
                else begin
                    Rout   = 16'h0001 << rc;
                    alu_op = op[3:0] - 4'd2;
                end
            end
            S_T5: begin
                Zloout = 1'b1;
                if (is_alu)     Rin   = 16'h0001 << ra;
                else if (is_md) LOin  = 1'b1;
                else            MARin = 1'b1;
            end
            S_T6: begin
                if (is_md) begin Zhiout = 1'b1; HIin = 1'b1; end
                else if (is_ld) begin Read = 1'b1; MDRin = 1'b1; end
                else begin Rout = 16'h0001 << ra; MDRin = 1'b1; end
            end
            S_T7: begin
                if (is_ld) begin MDRout = 1'b1; Rin = 16'h0001 << ra; end
                else       Write = 1'b1;
            end
            S_HALT: begin
                halted  = 1'b1;
                illegal = (state_q == S_DISP) ? is_ill : illegal_q;
            end
            default: ;
        endcase
    end

    assign tstate = cur;

endmodule

// File: tb/tb_mini_src_control_unit.sv
// tb/tb_mini_src_control_unit.sv - randomized microsequence check of mini_src_control_unit
module tb_mini_src_control_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        mem_ready = 1'b0;
    logic        PCout, Zhiout, Zloout, MDRout, Cout, PCin, IRin, MARin, MDRin;
    logic        Yin, Zin, HIin, LOin, IncPC, Read, Write, halted, illegal;
    logic [15:0] Rin, Rout;
    logic [3:0]  alu_op, tstate;
    logic [31:0] c_sext;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [15:0] PCO = 16'h8000, ZHO = 16'h4000, ZLO = 16'h2000, MDRO = 16'h1000;
    localparam logic [15:0] CO  = 16'h0800, PCI = 16'h0400, IRI = 16'h0200, MARI = 16'h0100;
    localparam logic [15:0] MDRI = 16'h0080, YI = 16'h0040, ZI = 16'h0020, HII = 16'h0010;
    localparam logic [15:0] LOI = 16'h0008, INC = 16'h0004, RD = 16'h0002, WR = 16'h0001;

    mini_src_control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zhiout(Zhiout), .Zloout(Zloout), .MDRout(MDRout), .Cout(Cout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .c_sext(c_sext), .tstate(tstate),
        .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [57:0] observed();
        return {PCout, Zhiout, Zloout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin,
                HIin, LOin, IncPC, Read, Write, Rin, Rout, alu_op, tstate, halted, illegal};
    endfunction

    function automatic logic [57:0] ev(input logic [15:0] c, input logic [15:0] ri,
                                       input logic [15:0] ro, input logic [3:0] alu,
                                       input logic [3:0] ts, input logic h, input logic il);
        return {c, ri, ro, alu, ts, h, il};
    endfunction

    function automatic logic [15:0] oh(input int n);
        logic [15:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // ALU code table by mnemonic opcode
    function automatic logic [3:0] alu_of(input int op);
        case (op)
            2: return 4'd0;   3: return 4'd1;   4: return 4'd2;   5: return 4'd3;
            6: return 4'd4;   7: return 4'd5;   8: return 4'd6;   9: return 4'd7;
            10: return 4'd8;  11: return 4'd9;  12: return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

    logic [57:0] exp_q[$];
    bit          wait_q[$];

    task automatic build(input logic [31:0] instr);
        int op, a, b, c;
        op = int'(instr[31:27]);
        a  = int'(instr[26:23]);
        b  = int'(instr[22:19]);
        c  = int'(instr[18:15]);
        exp_q.delete();
        wait_q.delete();
        exp_q.push_back(ev(PCO | MARI | INC, 0, 0, 0, 1, 0, 0)); wait_q.push_back(0);
        exp_q.push_back(ev(RD | MDRI, 0, 0, 0, 2, 0, 0));        wait_q.push_back(1);
        exp_q.push_back(ev(MDRO | IRI, 0, 0, 0, 3, 0, 0));       wait_q.push_back(0);
        if (op >= 0 && op <= 12) begin
            exp_q.push_back(ev(YI, 0, oh(b), 0, 4, 0, 0)); wait_q.push_back(0);
            if (op <= 1) exp_q.push_back(ev(CO | ZI, 0, 0, 0, 5, 0, 0));
            else         exp_q.push_back(ev(ZI, 0, oh(c), alu_of(op), 5, 0, 0));
            wait_q.push_back(0);
            if (op >= 2 && op <= 10) begin
                exp_q.push_back(ev(ZLO, oh(a), 0, 0, 6, 0, 0)); wait_q.push_back(0);
            end else if (op >= 11) begin
                exp_q.push_back(ev(ZLO | LOI, 0, 0, 0, 6, 0, 0)); wait_q.push_back(0);
                exp_q.push_back(ev(ZHO | HII, 0, 0, 0, 7, 0, 0)); wait_q.push_back(0);
            end else if (op == 0) begin
                exp_q.push_back(ev(ZLO | MARI, 0, 0, 0, 6, 0, 0)); wait_q.push_back(0);
                exp_q.push_back(ev(RD | MDRI, 0, 0, 0, 7, 0, 0));  wait_q.push_back(1);
                exp_q.push_back(ev(MDRO, oh(a), 0, 0, 8, 0, 0));   wait_q.push_back(0);
            end else begin
                exp_q.push_back(ev(ZLO | MARI, 0, 0, 0, 6, 0, 0)); wait_q.push_back(0);
                exp_q.push_back(ev(MDRI, 0, oh(a), 0, 7, 0, 0));   wait_q.push_back(0);
                exp_q.push_back(ev(WR, 0, 0, 0, 8, 0, 0));         wait_q.push_back(1);
            end
        end else if (op == 25) begin
            exp_q.push_back(ev(0, 0, 0, 0, 15, 1, 0)); wait_q.push_back(0);
        end else if (op != 24) begin
            exp_q.push_back(ev(0, 0, 0, 0, 15, 1, 1)); wait_q.push_back(0);
        end
    endtask

    task automatic one_cycle(input string tag, input logic [57:0] exp, input logic mr);
        mem_ready = mr;
        #1;
        check(tag, 64'(observed()), 64'(exp));
        check("c_sext", 64'(c_sext), 64'({{13{ir[18]}}, ir[18:0]}));
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        #1;
        check("reset_now", 64'(observed()), 64'(0));
        check("reset_csext", 64'(c_sext), 64'({{13{ir[18]}}, ir[18:0]}));
        @(posedge clock);
        #1;
        check("reset_held", 64'(observed()), 64'(0));
        clear = 1'b1;
        #1;
        check("reset_state", 64'(observed()), 64'(0));
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] instr, input int fixed_k, input bit abort_st);
        int k;
        build(instr);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 3) ir = instr;
            if (exp_q[i][1]) begin
                for (int n = 0; n < 10; n++) one_cycle("halt", exp_q[i], 1'($urandom_range(0, 1)));
                do_reset();
                return;
            end
            if (wait_q[i]) begin
                k = (i >= 3 && fixed_k >= 0) ? fixed_k : int'($urandom_range(0, 3));
                if (abort_st && i >= 3) begin
                    one_cycle("st_wait", exp_q[i], 1'b0);
                    do_reset();
                    return;
                end
                for (int n = 0; n < k; n++) one_cycle("wait", exp_q[i], 1'b0);
                one_cycle("wait_done", exp_q[i], 1'b1);
            end else begin
                one_cycle("step", exp_q[i], 1'($urandom_range(0, 1)));
            end
        end
        if (exp_q.size() == 3) ir = instr;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = int'($urandom_range(0, 19));
        if (sel < 13)       r[31:27] = 5'(sel);
        else if (sel < 17)  r[31:27] = 5'($urandom_range(0, 12));
        else if (sel == 17) r[31:27] = 5'd24;
        else if (sel == 18) r[31:27] = 5'd25;
        else                r[31:27] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(13, 23))
                                                                 : 5'($urandom_range(26, 31));
        return r;
    endfunction

    initial begin
        #1;
        clear = 1'b0;
        ir = 32'h0000_0000;
        @(posedge clock);
        #1;
        do_reset();
        run_instr(32'h1299_0000, -1, 0);
        run_instr(32'h0097_FFFC, 3, 0);
        check("ld_csext", 64'(c_sext), 64'(32'hFFFF_FFFC));
        run_instr(32'h5833_8000, -1, 0);
        run_instr(32'hC000_0000, -1, 0);
        run_instr(32'h09A0_0008, 2, 0);
        run_instr(32'h09A0_0008, 5, 1);
        run_instr(32'hC800_0000, -1, 0);
        run_instr(32'hF800_0000, -1, 0);
        for (int t = 0; t < 80; t++) run_instr(rand_instr(), -1, ($urandom_range(0, 15) == 0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
